// File: rtl/ws2812_strip_controller_pkg.sv
// Shared constants, FSM encodings, pixel payload type and colour helpers
// for the WS2812 strip controller.
package ws2812_strip_controller_pkg;

  localparam int unsigned DEF_NUM_LEDS   = 8;
  localparam int unsigned DEF_T0H_CYC    = 4;
  localparam int unsigned DEF_T1H_CYC    = 8;
  localparam int unsigned DEF_TBIT_CYC   = 12;
  localparam int unsigned DEF_TRESET_CYC = 500;
  localparam int unsigned DEF_STALL_CYC  = 250;

  localparam int unsigned ORDER_GRB = 0;
  localparam int unsigned ORDER_RGB = 1;

  localparam int unsigned PIX_W = 24;
  localparam int unsigned IDX_W = 5;

  localparam logic [2:0] ST_PRELATCH = 3'd0;
  localparam logic [2:0] ST_IDLE     = 3'd1;
  localparam logic [2:0] ST_FETCH    = 3'd2;
  localparam logic [2:0] ST_SHIFT    = 3'd3;
  localparam logic [2:0] ST_LATCH    = 3'd4;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  // (c * (br + 1)) >> 8: br=255 is identity, br=0 blanks the channel
  function automatic logic [7:0] scale_chan(input logic [7:0] c, input logic [7:0] br);
    logic [16:0] prod;
    prod = 17'(c) * (17'(br) + 17'd1);
    return 8'(prod >> 8);
  endfunction

  function automatic logic [PIX_W-1:0] wire_word(input pixel_t p, input logic [7:0] br,
                                                 input logic rgb_order);
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
    r = scale_chan(p.r, br);
    g = scale_chan(p.g, br);
    b = scale_chan(p.b, br);
    return rgb_order ? {r, g, b} : {g, r, b};
  endfunction

endpackage

// File: rtl/ws2812_bit_encoder.sv
// Generates one WS2812 bit waveform: high for T0H/T1H cycles, low for the
// rest of a TBIT_CYC period. bit_done is high during the last cycle of the bit.
module ws2812_bit_encoder #(
  parameter int unsigned T0H_CYC  = 4,
  parameter int unsigned T1H_CYC  = 8,
  parameter int unsigned TBIT_CYC = 12
) (
  input  logic clk,
  input  logic rst,
  input  logic go,
  input  logic bit_val,
  output logic data_out,
  output logic bit_done
);

  localparam int unsigned CNT_W = $clog2(TBIT_CYC);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(TBIT_CYC - 1);
  localparam logic [CNT_W-1:0] HI0   = CNT_W'(T0H_CYC);
  localparam logic [CNT_W-1:0] HI1   = CNT_W'(T1H_CYC);

  logic             active;
  logic             bit_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] hi_len;

  assign cnt_inc = cnt + CNT_W'(1);
  assign hi_len  = bit_q ? HI1 : HI0;

  always_ff @(posedge clk) begin
    if (rst) begin
      active   <= 1'b0;
      bit_q    <= 1'b0;
      cnt      <= '0;
      data_out <= 1'b0;
      bit_done <= 1'b0;
    end else if (go) begin
      active   <= 1'b1;
      bit_q    <= bit_val;
      cnt      <= '0;
      data_out <= 1'b1;
      bit_done <= 1'b0;
    end else if (active) begin
      if (cnt == LAST) begin
        active   <= 1'b0;
        data_out <= 1'b0;
        bit_done <= 1'b0;
      end else begin
        cnt      <= cnt_inc;
        data_out <= cnt_inc < hi_len;
        bit_done <= cnt_inc == LAST;
      end
    end
  end

endmodule

// File: rtl/ws2812_strip_controller.sv
// WS2812 chain driver: fetches NUM_LEDS pixels from a valid/ready source,
// scales and serialises them, then latches the strip with a long low interval.
module ws2812_strip_controller
  import ws2812_strip_controller_pkg::*;
#(
  parameter int unsigned NUM_LEDS   = DEF_NUM_LEDS,
  parameter int unsigned T0H_CYC    = DEF_T0H_CYC,
  parameter int unsigned T1H_CYC    = DEF_T1H_CYC,
  parameter int unsigned TBIT_CYC   = DEF_TBIT_CYC,
  parameter int unsigned TRESET_CYC = DEF_TRESET_CYC,
  parameter int unsigned STALL_CYC  = DEF_STALL_CYC,
  parameter int unsigned ORDER      = ORDER_GRB
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] brightness,
  input  logic       pix_valid,
  output logic       pix_ready,
  input  logic [7:0] pix_r,
  input  logic [7:0] pix_g,
  input  logic [7:0] pix_b,
  output logic       busy,
  output logic       frame_done,
  output logic       underrun,
  output logic       data_out
);

  localparam int unsigned TCNT_W  = $clog2(TRESET_CYC + 1);
  localparam int unsigned STALL_W = $clog2(STALL_CYC + 1);
  localparam int unsigned PIXC_W  = $clog2(NUM_LEDS + 1);

  logic [2:0]         state, state_n;
  logic [TCNT_W-1:0]  tcnt, tcnt_n;
  logic [STALL_W-1:0] stall, stall_n;
  logic [PIXC_W-1:0]  pix_cnt, pix_cnt_n;
  logic [IDX_W-1:0]   idx, idx_n;
  logic [PIX_W-1:0]   sreg, sreg_n;
  logic [7:0]         br_q, br_n;
  logic               frame_done_n, underrun_n;
  logic               enc_go, enc_bit, bit_done;
  logic [PIX_W-1:0]   word;
  pixel_t             pix_in;

  assign pix_in = '{r: pix_r, g: pix_g, b: pix_b};

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_PRELATCH;
      tcnt       <= '0;
      stall      <= '0;
      pix_cnt    <= '0;
      idx        <= '0;
      sreg       <= '0;
      br_q       <= '0;
      busy       <= 1'b0;
      pix_ready  <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state      <= state_n;
      tcnt       <= tcnt_n;
      stall      <= stall_n;
      pix_cnt    <= pix_cnt_n;
      idx        <= idx_n;
      sreg       <= sreg_n;
      br_q       <= br_n;
      busy       <= state_n != ST_IDLE;
      pix_ready  <= state_n == ST_FETCH;
      frame_done <= frame_done_n;
      underrun   <= underrun_n;
    end
  end

  always_comb begin
    state_n      = state;
    tcnt_n       = tcnt;
    stall_n      = stall;
    pix_cnt_n    = pix_cnt;
    idx_n        = idx;
    sreg_n       = sreg;
    br_n         = br_q;
    frame_done_n = 1'b0;
    underrun_n   = 1'b0;
    enc_go       = 1'b0;
    enc_bit      = 1'b0;
    word         = wire_word(pix_in, br_q, ORDER == ORDER_RGB);
    case (state)
      // PRELATCH starts with tcnt=0 while outputs still show reset, hence the extra count
      ST_PRELATCH: begin
        if (tcnt == TCNT_W'(TRESET_CYC)) begin
          state_n = ST_IDLE;
          tcnt_n  = '0;
        end else begin
          tcnt_n = tcnt + TCNT_W'(1);
        end
      end
      ST_IDLE: begin
        if (start) begin
          br_n      = brightness;
          pix_cnt_n = '0;
          stall_n   = '0;
          state_n   = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (pix_valid && pix_ready) begin
          sreg_n  = word;
          idx_n   = '0;
          enc_go  = 1'b1;
          enc_bit = word[PIX_W-1];
          stall_n = '0;
          state_n = ST_SHIFT;
        end else if (stall == STALL_W'(STALL_CYC - 1)) begin
          underrun_n = 1'b1;
          tcnt_n     = '0;
          state_n    = ST_LATCH;
        end else begin
          stall_n = stall + STALL_W'(1);
        end
      end
      ST_SHIFT: begin
        if (bit_done) begin
          if (idx == IDX_W'(PIX_W - 1)) begin
            pix_cnt_n = pix_cnt + PIXC_W'(1);
            if (pix_cnt_n == PIXC_W'(NUM_LEDS)) begin
              tcnt_n  = '0;
              state_n = ST_LATCH;
            end else begin
              stall_n = '0;
              state_n = ST_FETCH;
            end
          end else begin
            idx_n   = idx + IDX_W'(1);
            sreg_n  = sreg << 1;
            enc_go  = 1'b1;
            enc_bit = sreg[PIX_W-2];
          end
        end
      end
      ST_LATCH: begin
        if (tcnt == TCNT_W'(TRESET_CYC - 1)) begin
          tcnt_n       = '0;
          frame_done_n = 1'b1;
          state_n      = ST_IDLE;
        end else begin
          tcnt_n = tcnt + TCNT_W'(1);
        end
      end
      default: state_n = ST_PRELATCH;
    endcase
  end

  ws2812_bit_encoder #(
    .T0H_CYC (T0H_CYC),
    .T1H_CYC (T1H_CYC),
    .TBIT_CYC(TBIT_CYC)
  ) u_enc (
    .clk     (clk),
    .rst     (rst),
    .go      (enc_go),
    .bit_val (enc_bit),
    .data_out(data_out),
    .bit_done(bit_done)
  );

endmodule

// File: tb/tb_ws2812_strip_controller.sv
// Scoreboard bench: dut0 is NUM_LEDS=1/GRB, dut1 is NUM_LEDS=3/RGB; a monitor
// decodes the serial line and pulses and matches them against queued expectations.
module tb_ws2812_strip_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #50 clk = ~clk;

  logic       s0_start, s0_valid, s0_ready, s0_busy, s0_done, s0_under, s0_dout;
  logic [7:0] s0_br, s0_r, s0_g, s0_b;
  logic       s1_start, s1_valid, s1_ready, s1_busy, s1_done, s1_under, s1_dout;
  logic [7:0] s1_br, s1_r, s1_g, s1_b;

  ws2812_strip_controller #(.NUM_LEDS(1), .ORDER(0)) dut0 (
    .clk(clk), .rst(rst), .start(s0_start), .brightness(s0_br),
    .pix_valid(s0_valid), .pix_ready(s0_ready),
    .pix_r(s0_r), .pix_g(s0_g), .pix_b(s0_b),
    .busy(s0_busy), .frame_done(s0_done), .underrun(s0_under), .data_out(s0_dout)
  );

  ws2812_strip_controller #(.NUM_LEDS(3), .ORDER(1)) dut1 (
    .clk(clk), .rst(rst), .start(s1_start), .brightness(s1_br),
    .pix_valid(s1_valid), .pix_ready(s1_ready),
    .pix_r(s1_r), .pix_g(s1_g), .pix_b(s1_b),
    .busy(s1_busy), .frame_done(s1_done), .underrun(s1_under), .data_out(s1_dout)
  );

  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] val;
  } ev_t;

  localparam logic [1:0]  K_BYTE  = 2'd0;
  localparam logic [1:0]  K_FDONE = 2'd1;
  localparam logic [1:0]  K_UNDER = 2'd2;
  localparam logic [15:0] ANY     = 16'hFFFF;

  ev_t exp_q0[$];
  ev_t exp_q1[$];
  int  checks = 0;
  int  errors = 0;

  int         hi   [2];
  int         lo   [2];
  int         rdy  [2];
  int         bitn [2];
  int         hs   [2];
  logic [7:0] shb  [2];

  task automatic check(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      errors++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end
  endtask

  task automatic expect_ev(input int d, input logic [1:0] k, input logic [15:0] v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    if (d == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endtask

  task automatic expect_bytes(input int d, input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2);
    expect_ev(d, K_BYTE, {8'h00, b0});
    expect_ev(d, K_BYTE, {8'h00, b1});
    expect_ev(d, K_BYTE, {8'h00, b2});
  endtask

  task automatic observe(input int d, input logic [1:0] k, input logic [15:0] v);
    ev_t e;
    int  sz;
    checks++;
    sz = (d == 0) ? exp_q0.size() : exp_q1.size();
    if (sz == 0) begin
      errors++;
      $display("FAIL unexpected_event dut%0d got kind=%0d val=%0h required=none", d, k, v);
    end else begin
      if (d == 0) e = exp_q0.pop_front();
      else        e = exp_q1.pop_front();
      if (e.kind != k || (e.val != ANY && e.val != v)) begin
        errors++;
        $display("FAIL event dut%0d got kind=%0d val=%0h required kind=%0d val=%0h",
                 d, k, v, e.kind, e.val);
      end
    end
  endtask

  // Line decoder and pulse monitor, sampled on the inactive edge
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic dout, fd, ur, pr, pv;
      dout = (i == 0) ? s0_dout  : s1_dout;
      fd   = (i == 0) ? s0_done  : s1_done;
      ur   = (i == 0) ? s0_under : s1_under;
      pr   = (i == 0) ? s0_ready : s1_ready;
      pv   = (i == 0) ? s0_valid : s1_valid;
      if (rst) begin
        hi[i] = 0; lo[i] = 0; rdy[i] = 0; bitn[i] = 0;
      end else begin
        if (fd) observe(i, K_FDONE, 16'(lo[i]));
        if (ur) observe(i, K_UNDER, 16'(rdy[i]));
        if (dout) begin
          hi[i]++;
          lo[i] = 0;
        end else begin
          if (hi[i] != 0) begin
            checks++;
            if (hi[i] != 4 && hi[i] != 8) begin
              errors++;
              $display("FAIL pulse_width dut%0d got=%0d required=4_or_8", i, hi[i]);
            end
            shb[i]  = {shb[i][6:0], hi[i] == 8};
            bitn[i] = bitn[i] + 1;
            if (bitn[i] == 8) begin
              observe(i, K_BYTE, {8'h00, shb[i]});
              bitn[i] = 0;
            end
            hi[i] = 0;
          end
          lo[i]++;
        end
        rdy[i] = pr ? rdy[i] + 1 : 0;
        if (pv && pr) hs[i]++;
      end
    end
  end

  task automatic drive(input int d, input logic v, input logic [7:0] r, input logic [7:0] g,
                       input logic [7:0] b);
    if (d == 0) begin s0_valid = v; s0_r = r; s0_g = g; s0_b = b; end
    else        begin s1_valid = v; s1_r = r; s1_g = g; s1_b = b; end
  endtask

  task automatic send_pix(input int d, input logic [7:0] r, input logic [7:0] g,
                          input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    drive(d, 1'b1, r, g, b);
    for (int n = 0; n < 3000 && !ok; n++) begin
      if ((d == 0) ? s0_ready : s1_ready) ok = 1'b1;
      @(negedge clk);
    end
    drive(d, 1'b0, r, g, b);
    if (!ok) check("pixel_handshake_timeout", 0, 1);
  endtask

  task automatic start_frame(input int d, input logic [7:0] br);
    @(negedge clk);
    if (d == 0) begin s0_start = 1'b1; s0_br = br; end
    else        begin s1_start = 1'b1; s1_br = br; end
    @(negedge clk);
    if (d == 0) s0_start = 1'b0;
    else        s1_start = 1'b0;
  endtask

  task automatic wait_done(input int d);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 5000 && !seen; n++) begin
      @(negedge clk);
      if ((d == 0) ? s0_done : s1_done) seen = 1'b1;
    end
    if (!seen) check("frame_done_timeout", 0, 1);
  endtask

  task automatic prelatch_len(output int n);
    n = 0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (s0_busy) n++;
      else if (n != 0) break;
    end
  endtask

  initial begin
    int n;
    int base;
    s0_start = 0; s0_br = 0; s0_valid = 0; s0_r = 0; s0_g = 0; s0_b = 0;
    s1_start = 0; s1_br = 0; s1_valid = 0; s1_r = 0; s1_g = 0; s1_b = 0;
    for (int i = 0; i < 2; i++) begin
      hi[i] = 0; lo[i] = 0; rdy[i] = 0; bitn[i] = 0; hs[i] = 0; shb[i] = 8'h00;
    end

    // Reset values and power-up latch
    repeat (3) @(negedge clk);
    check("reset_outputs_dut0", 32'({s0_busy, s0_ready, s0_done, s0_under, s0_dout}), 0);
    check("reset_outputs_dut1", 32'({s1_busy, s1_ready, s1_done, s1_under, s1_dout}), 0);
    rst = 1'b0;
    prelatch_len(n);
    check("prelatch_busy_cycles", n, 500);

    // Test 1: r=255 g=0 b=128 full brightness, GRB
    expect_bytes(0, 8'h00, 8'hFF, 8'h80);
    expect_ev(0, K_FDONE, 16'd508);
    start_frame(0, 8'd255);
    send_pix(0, 8'd255, 8'd0, 8'd128);
    wait_done(0);

    // Test 2: brightness 127 scales 200 to 0x64
    expect_bytes(0, 8'h00, 8'h64, 8'h00);
    expect_ev(0, K_FDONE, 16'd508);
    start_frame(0, 8'd127);
    send_pix(0, 8'd200, 8'd0, 8'd0);
    wait_done(0);

    // Test 4: start held through the frame and its frame_done cycle
    expect_bytes(0, 8'h34, 8'h12, 8'h56);
    expect_ev(0, K_FDONE, 16'd508);
    expect_bytes(0, 8'h34, 8'h12, 8'h56);
    expect_ev(0, K_FDONE, 16'd508);
    @(negedge clk);
    s0_start = 1'b1;
    s0_br    = 8'd255;
    send_pix(0, 8'h12, 8'h34, 8'h56);
    check("busy_while_start_held", 32'(s0_busy), 1);
    wait_done(0);
    @(negedge clk);
    check("start_in_done_cycle_accepted", 32'(s0_busy), 1);
    s0_start = 1'b0;
    send_pix(0, 8'h12, 8'h34, 8'h56);
    wait_done(0);

    // Test 3: dut1 stalls after pixel 1 -> underrun, latch, no further pixels taken
    expect_bytes(1, 8'h01, 8'h02, 8'h03);
    expect_ev(1, K_UNDER, 16'd250);
    expect_ev(1, K_FDONE, ANY);
    base = hs[1];
    start_frame(1, 8'd255);
    send_pix(1, 8'h01, 8'h02, 8'h03);
    for (int k = 0; k < 1000 && !s1_ready; k++) @(negedge clk);
    check("ready_after_pixel1", 32'(s1_ready), 1);
    repeat (300) @(negedge clk);
    check("latching_after_underrun", 32'({s1_busy, s1_ready}), 2);
    drive(1, 1'b1, 8'h44, 8'h55, 8'h66);
    wait_done(1);
    drive(1, 1'b0, 8'h00, 8'h00, 8'h00);
    check("underrun_pixels_consumed", hs[1] - base, 1);

    // Test 6: RGB order on the wire, three pixels
    for (int p = 0; p < 3; p++) expect_bytes(1, 8'hA5, 8'h00, 8'hFF);
    expect_ev(1, K_FDONE, 16'd504);
    start_frame(1, 8'd255);
    for (int p = 0; p < 3; p++) send_pix(1, 8'hA5, 8'h00, 8'hFF);
    wait_done(1);

    // Test 5: reset in the high phase of bit 1, then re-run the power-up latch
    start_frame(0, 8'd255);
    send_pix(0, 8'hFF, 8'hFF, 8'hFF);
    repeat (15) @(negedge clk);
    check("high_before_reset", 32'(s0_dout), 1);
    rst = 1'b1;
    @(negedge clk);
    check("low_after_reset", 32'(s0_dout), 0);
    repeat (2) @(negedge clk);
    s0_start = 1'b1;
    rst      = 1'b0;
    prelatch_len(n);
    s0_start = 1'b0;
    check("prelatch_after_reset_busy_cycles", n, 500);
    repeat (5) @(negedge clk);
    check("idle_after_prelatch", 32'(s0_busy), 0);

    check("pending_expectations_dut0", exp_q0.size(), 0);
    check("pending_expectations_dut1", exp_q1.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
